// File: rtl/cpu_div_cell_if.sv
// Request/response bundle between the CPU issue stage and the divider cell.
// Handshake: the master raises A_div_start with operands for one cycle; the cell accepts it only while A_div_busy is low, and A_div_done pulses once per accepted operation with results held until the next done.
interface cpu_div_cell_if #(
    parameter int WIDTH = 32
);
    logic             A_div_start;
    logic             A_div_signed;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quotient;
    logic [WIDTH-1:0] A_div_remainder;
    logic             A_div_by_zero;

    modport master (
        output A_div_start,
        output A_div_signed,
        output A_div_src1,
        output A_div_src2,
        input  A_div_busy,
        input  A_div_done,
        input  A_div_quotient,
        input  A_div_remainder,
        input  A_div_by_zero
    );

    modport slave (
        input  A_div_start,
        input  A_div_signed,
        input  A_div_src1,
        input  A_div_src2,
        output A_div_busy,
        output A_div_done,
        output A_div_quotient,
        output A_div_remainder,
        output A_div_by_zero
    );
endinterface

// File: rtl/cpu_div_cell.sv
// Radix-2 restoring divider (signed/unsigned) with start/done handshake and IDLE/CALC/FIX FSM.
// Optional CPU_DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module cpu_div_cell #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    cpu_div_cell_if.slave div,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             by_zero_q, by_zero_d;
    logic             done_q, done_d;

    logic             src1_neg, src2_neg, src2_zero, early_out;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   shifted, diff;
    logic             last_iter;
    logic             busy;

    assign src1_neg  = div.A_div_signed & div.A_div_src1[WIDTH-1];
    assign src2_neg  = div.A_div_signed & div.A_div_src2[WIDTH-1];
    assign src2_zero = (div.A_div_src2 == '0);
    assign mag1      = src1_neg ? (-div.A_div_src1) : div.A_div_src1;
    assign mag2      = src2_neg ? (-div.A_div_src2) : div.A_div_src2;

`ifdef CPU_DIV_EARLY_OUT_EN
    assign early_out = !src2_zero && (mag1 < mag2);
`else
    assign early_out = 1'b0;
`endif

    // Partial remainder kept one bit wider so divisors with MSB set never overflow the trial.
    assign shifted   = {rem_q, dvd_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (div.A_div_start) begin
                    state_d = (src2_zero || early_out) ? FIX : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        dbg_state_o = state_q;
    end

    always_comb begin
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        by_zero_d   = by_zero_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (div.A_div_start) begin
                    neg_quo_d = src1_neg ^ src2_neg;
                    neg_rem_d = src1_neg;
                    zero_d    = src2_zero;
                    dvs_d     = mag2;
                    cnt_d     = '0;
                    dvd_d     = mag1;
                    rem_d     = '0;
                    // Short paths park |src1| as the remainder so FIX's sign fixup returns src1.
                    if (src2_zero) begin
                        rem_d = mag1;
                    end else if (early_out) begin
                        rem_d = mag1;
                        dvd_d = '0;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                quotient_d  = zero_q ? '1 : (neg_quo_q ? (-dvd_q) : dvd_q);
                remainder_d = neg_rem_q ? (-rem_q) : rem_q;
                by_zero_d   = zero_q;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            by_zero_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            by_zero_q   <= by_zero_d;
            done_q      <= done_d;
        end
    end

    assign div.A_div_busy      = busy;
    assign div.A_div_done      = done_q;
    assign div.A_div_quotient  = quotient_q;
    assign div.A_div_remainder = remainder_q;
    assign div.A_div_by_zero   = by_zero_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Directed plus random bench for cpu_div_cell: expected results are queued at launch and checked on each done.
// Latencies are counted in clock edges after the edge that accepts start.
module tb_cpu_div_cell;

    localparam int          W         = 32;
    localparam int          LAT_FULL  = W + 1;
    localparam int          LAT_SHORT = 1;
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
`ifdef CPU_DIV_EARLY_OUT_EN
    localparam bit          EARLY_EN  = 1'b1;
`else
    localparam bit          EARLY_EN  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    cpu_div_cell_if #(.WIDTH(W)) dif ();

    cpu_div_cell #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .div         (dif),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Scoreboard entry: {by_zero, remainder, quotient}
    logic [2*W:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb, sq, sr;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (!sgn) return {1'b0, a % b, a / b};
        if (a == MIN_NEG && b == {W{1'b1}}) return {1'b0, {W{1'b0}}, MIN_NEG};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr, sq};
    endfunction

    function automatic int exp_lat(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ma, mb;
        if (b == '0) return LAT_SHORT;
        ma = (sgn && a[W-1]) ? -a : a;
        mb = (sgn && b[W-1]) ? -b : b;
        if (EARLY_EN && ma < mb) return LAT_SHORT;
        return LAT_FULL;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (dif.A_div_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", W'(dif.A_div_done), '0);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("quotient", dif.A_div_quotient, e[W-1:0]);
                check("remainder", dif.A_div_remainder, e[2*W-1:W]);
                check("by_zero", W'(dif.A_div_by_zero), W'(e[2*W]));
            end
        end
    end

    // Drivers: caller is at a negedge with the cell able to accept.
    task automatic launch(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W:0] e);
        dif.A_div_start  = 1'b1;
        dif.A_div_signed = sgn;
        dif.A_div_src1   = a;
        dif.A_div_src2   = b;
        exp_q.push_back(e);
        @(negedge clk);
        dif.A_div_start  = 1'b0;
        dif.A_div_signed = 1'($urandom_range(0, 1));
        dif.A_div_src1   = $urandom;
        dif.A_div_src2   = $urandom;
    endtask

    // Returns at the negedge of the done cycle (or after the timeout bound).
    task automatic wait_done(input string tag, input int lat, input int inject_at);
        int i;
        bit busy_ok;
        i = 0;
        busy_ok = 1'b1;
        while (dif.A_div_done !== 1'b1 && i < LAT_FULL + 8) begin
            if (dif.A_div_busy !== 1'b1) busy_ok = 1'b0;
            dif.A_div_start = (i == inject_at);
            if (i == inject_at) begin
                dif.A_div_signed = 1'b0;
                dif.A_div_src1   = 32'd5;
                dif.A_div_src2   = 32'd1;
            end
            @(negedge clk);
            i++;
        end
        dif.A_div_start = 1'b0;
        check({tag, "_latency"}, W'(i), W'(lat));
        check({tag, "_busy_during"}, W'(busy_ok), W'(1));
        check({tag, "_busy_at_done"}, W'(dif.A_div_busy), '0);
    endtask

    task automatic run_dir(input string tag, input bit sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W:0] e);
        launch(sgn, a, b, e);
        wait_done(tag, exp_lat(sgn, a, b), -1);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, W'(dif.A_div_busy), '0);
        check({tag, "_done"}, W'(dif.A_div_done), '0);
        check({tag, "_quotient"}, dif.A_div_quotient, '0);
        check({tag, "_remainder"}, dif.A_div_remainder, '0);
        check({tag, "_by_zero"}, W'(dif.A_div_by_zero), '0);
        check({tag, "_state"}, W'(dbg_state), '0);
    endtask

    initial begin
        reset            = 1'b1;
        dif.A_div_start  = 1'b0;
        dif.A_div_signed = 1'b0;
        dif.A_div_src1   = '0;
        dif.A_div_src2   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        run_dir("u100_7", 1'b0, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
        run_dir("s_m7_2", 1'b1, -32'sd7, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_dir("s_7_m2", 1'b1, 32'd7, -32'sd2, {1'b0, 32'd1, 32'hFFFF_FFFD});
        run_dir("div0_s", 1'b1, 32'h1234_5678, 32'd0, {1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
        run_dir("div0_u", 1'b0, 32'h1234_5678, 32'd0, {1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
        run_dir("div0_neg", 1'b1, 32'hF000_0001, 32'd0, {1'b1, 32'hF000_0001, 32'hFFFF_FFFF});
        run_dir("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000});
        run_dir("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {1'b0, 32'd0, 32'hFFFF_FFFF});
        run_dir("u_big_div", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {1'b0, 32'd1, 32'd1});
        run_dir("u3_10", 1'b0, 32'd3, 32'd10, {1'b0, 32'd3, 32'd0});
        run_dir("s_m3_10", 1'b1, -32'sd3, 32'd10, {1'b0, 32'hFFFF_FFFD, 32'd0});

        // Start pulsed mid-operation must be ignored.
        launch(1'b0, 32'd1000, 32'd9, {1'b0, 32'd1, 32'd111});
        wait_done("ignore_start", LAT_FULL, 5);
        repeat (LAT_FULL + 4) @(negedge clk);

        // Start in the done cycle is accepted back-to-back.
        launch(1'b0, 32'd50, 32'd6, {1'b0, 32'd2, 32'd8});
        wait_done("b2b_first", LAT_FULL, -1);
        launch(1'b1, -32'sd50, 32'd6, {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF8});
        wait_done("b2b_second", LAT_FULL, -1);
        @(negedge clk);

        // Reset at iteration 10 aborts without done.
        launch(1'b0, 32'd12345, 32'd7, {1'b0, 32'd4, 32'd1763});
        repeat (10) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check_idle("abort");
        repeat (LAT_FULL + 4) @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            bit           sgn;
            logic [W-1:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            if ($urandom_range(0, 1) == 1) b = -b;
            if (k == 11) b = '0;
            run_dir($sformatf("rand%0d", k), sgn, a, b, model(sgn, a, b));
        end

        check("queue_empty", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
